// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/writeback with a
// sticky trap state for illegal opcodes and misaligned jump targets.
module riscv_mc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic [31:0] target,
    output logic [2:0]  imm_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        trap
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] next_pc;
    logic        is_jal, is_jalr, is_branch, is_load, is_store, is_fence;
    logic        legal, jump;
    logic [31:0] exec_pc;

    assign imem_addr = pc;

    always_comb begin
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_branch = (opcode == OP_BRANCH);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_fence  = (opcode == OP_FENCE);
        legal     = (opcode == OP_LUI) || (opcode == OP_AUIPC) || is_jal || is_jalr ||
                    is_branch || is_load || is_store || (opcode == OP_IMM) ||
                    (opcode == OP_OP) || is_fence;
        jump      = is_jal || is_jalr || (is_branch && br_taken);
        exec_pc   = jump ? target : pc + 32'd4;
    end

    always_comb begin
        imm_sel = 3'd0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_sel = 3'd0;
            OP_STORE:                 imm_sel = 3'd1;
            OP_BRANCH:                imm_sel = 3'd2;
            OP_LUI, OP_AUIPC:         imm_sel = 3'd3;
            OP_JAL:                   imm_sel = 3'd4;
            default:                  imm_sel = 3'd0;
        endcase
    end

    // Retirement (pc, instret, retire pulse) lands on the edge that re-enters
    // FETCH, so all three become visible in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            next_pc  <= RESET_PC;
            ir       <= 32'd0;
            instret  <= 32'd0;
            trap     <= 1'b0;
            retire   <= 1'b0;
            reg_we   <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            imem_req <= 1'b1;
        end else begin
            retire <= 1'b0;
            reg_we <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        trap  <= 1'b1;
                        state <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    next_pc <= exec_pc;
                    if (jump && (target[1:0] != 2'b00)) begin
                        trap  <= 1'b1;
                        state <= S_TRAP;
                    end else if (is_load || is_store) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= is_store;
                        state    <= S_MEM;
                    end else if (is_branch || is_fence) begin
                        pc       <= exec_pc;
                        instret  <= instret + 32'd1;
                        retire   <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        reg_we <= 1'b1;
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (is_load) begin
                            reg_we <= 1'b1;
                            state  <= S_WB;
                        end else begin
                            pc       <= next_pc;
                            instret  <= instret + 32'd1;
                            retire   <= 1'b1;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    pc       <= next_pc;
                    instret  <= instret + 32'd1;
                    retire   <= 1'b1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    trap     <= 1'b1;
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    state    <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: directed instructions push expected
// retirement records; a negedge monitor checks each retire pulse against them.
module tb_riscv_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic        br_taken = 1'b0;
    logic [31:0] target = 32'd0;
    logic [2:0]  imm_sel;
    logic        dmem_req, dmem_we;
    logic        dmem_ack = 1'b0;
    logic        reg_we;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] instret;
    logic        trap;

    always #5 clk = ~clk;
    assign opcode = ir[6:0];

    riscv_mc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .opcode(opcode),
        .br_taken(br_taken), .target(target), .imm_sel(imm_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .pc(pc), .retire(retire), .instret(instret), .trap(trap)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        int          rwe;
        int          dm;
        int          dwe;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] w;
        logic        br;
        logic [31:0] t;
        int          iw;
        int          dw;
        logic [31:0] pc;
        int          rwe;
        int          dm;
        int          dwe;
        int          lat;
        logic [2:0]  imm;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vt[10];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: counts per-instruction activity and checks it on each retire.
    int cnt = -1, rwe_c = 0, dm_c = 0, dwe_c = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cnt = -1; rwe_c = 0; dm_c = 0; dwe_c = 0;
        end else begin
            cnt++;
            if (reg_we)   rwe_c++;
            if (dmem_req) dm_c++;
            if (dmem_we)  dwe_c++;
            if (retire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", {31'd0, retire}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ret_pc", pc, e.pc);
                    chk("ret_instret", instret, e.instret);
                    chk("ret_reg_we_cycles", rwe_c, e.rwe);
                    chk("ret_dmem_req_cycles", dm_c, e.dm);
                    chk("ret_dmem_we_cycles", dwe_c, e.dwe);
                    chk("ret_latency", cnt, e.lat);
                end
                cnt = 0; rwe_c = 0; dm_c = 0; dwe_c = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_instret = 32'd0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_instret", instret, 32'h0);
        chk("rst_flags", {27'd0, trap, retire, reg_we, dmem_req, dmem_we}, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_fetch", {31'd0, imem_req}, 32'd1);
        chk("rst_first_addr", imem_addr, 32'h0);
    endtask

    // Returns when imem_req is seen high at a negedge (or times out).
    task automatic wait_fetch(output bit ok);
        int t = 0;
        while (!imem_req && t < 40) begin
            @(negedge clk);
            t++;
        end
        ok = imem_req;
        if (!ok) chk("imem_req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic give_instr(input logic [31:0] w, input logic br, input logic [31:0] t, input int iw);
        repeat (iw) @(negedge clk);
        imem_rdata = w;
        br_taken   = br;
        target     = t;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    task automatic run(input vec_t v);
        bit   ok;
        exp_t e;
        int   t;
        wait_fetch(ok);
        if (!ok) return;
        exp_instret = exp_instret + 32'd1;
        e = '{v.pc, exp_instret, v.rwe, v.dm, v.dwe, v.lat};
        exp_q.push_back(e);
        give_instr(v.w, v.br, v.t, v.iw);
        chk("imm_sel", {29'd0, imm_sel}, {29'd0, v.imm});
        if (v.dw >= 0) begin
            t = 0;
            while (!dmem_req && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!dmem_req) begin
                chk("dmem_req_timeout", {31'd0, dmem_req}, 32'd1);
                return;
            end
            repeat (v.dw) @(negedge clk);
            dmem_ack = 1'b1;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        //            word          br    target  iw  dw  pc      rwe dm dwe lat imm
        vt[0] = '{32'h0010_0093, 1'b0, 32'h0,   0, -1, 32'h004, 1, 0, 0, 4, 3'd0}; // ADDI
        vt[1] = '{32'h0011_2023, 1'b0, 32'h0,   0,  3, 32'h008, 0, 4, 4, 7, 3'd1}; // SW
        vt[2] = '{32'h0001_2083, 1'b0, 32'h0,   0,  0, 32'h00C, 1, 1, 0, 5, 3'd0}; // LW
        vt[3] = '{32'h0000_0063, 1'b1, 32'h40,  0, -1, 32'h040, 0, 0, 0, 3, 3'd2}; // BEQ taken
        vt[4] = '{32'h0000_0063, 1'b0, 32'h80,  0, -1, 32'h044, 0, 0, 0, 3, 3'd2}; // BEQ not taken
        vt[5] = '{32'h0000_000F, 1'b0, 32'h0,   0, -1, 32'h048, 0, 0, 0, 3, 3'd0}; // FENCE
        vt[6] = '{32'h0000_10B7, 1'b0, 32'h0,   0, -1, 32'h04C, 1, 0, 0, 4, 3'd3}; // LUI
        vt[7] = '{32'h0000_80E7, 1'b0, 32'h100, 0, -1, 32'h100, 1, 0, 0, 4, 3'd0}; // JALR
        vt[8] = '{32'h0000_006F, 1'b0, 32'h200, 0, -1, 32'h200, 1, 0, 0, 4, 3'd4}; // JAL
        vt[9] = '{32'h0020_81B3, 1'b0, 32'h0,   2, -1, 32'h204, 1, 0, 0, 6, 3'd0}; // ADD, 2 fetch waits

        do_reset();
        for (int i = 0; i < 10; i++) run(vt[i]);
        drain();

        // Misaligned JAL target: sticky trap, pc frozen, acks ignored.
        wait_fetch(ok);
        if (ok) begin
            give_instr(32'h0000_006F, 1'b0, 32'h42, 0);
            chk("jal_trap_decode", {31'd0, trap}, 32'd0);
            @(negedge clk);
            chk("jal_trap_exec", {31'd0, trap}, 32'd0);
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("trap_hold", {26'd0, trap, imem_req, dmem_req, reg_we, retire, dmem_we}, 32'h20);
                chk("trap_pc", pc, 32'h204);
            end
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
        end

        // ECALL is illegal: trap becomes visible right after DECODE.
        do_reset();
        wait_fetch(ok);
        if (ok) begin
            give_instr(32'h0000_0073, 1'b0, 32'h0, 0);
            chk("ecall_decode", {31'd0, trap}, 32'd0);
            @(negedge clk);
            chk("ecall_trap", {31'd0, trap}, 32'd1);
            chk("ecall_pc", pc, 32'h0);
        end
        do_reset();

        // Reset in the middle of a LOAD's memory phase abandons it.
        wait_fetch(ok);
        if (ok) begin
            give_instr(32'h0001_2083, 1'b0, 32'h0, 0);
            repeat (2) @(negedge clk);
            chk("abandon_in_mem", {31'd0, dmem_req}, 32'd1);
        end
        do_reset();

        // instret wrap: preload FFFF_FFFF, one ADDI retires to 0.
        force dut.instret = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instret;
        chk("instret_preload", instret, 32'hFFFF_FFFF);
        exp_instret = 32'hFFFF_FFFF;
        run('{32'h0010_0093, 1'b0, 32'h0, 0, -1, 32'h004, 1, 0, 0, 5, 3'd0});
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
